// File: rtl/hard_mem_1rw_rv_adapter.sv
// hard_mem_1rw_rv_adapter
//   Front end for a byte-masked 1RW synchronous SRAM wrapper. Turns a
//   valid/ready request stream into raw per-cycle SRAM port activity. It also
//   returns read data on a valid/yumi stream through a small credit-managed
//   FIFO, so consumer backpressure never drops a word.
//
//   Optional build macro: HARD_MEM_ADAPTER_ZERO_INIT_EN
//     defined   -> after reset the array is swept with zeros (els_p cycles,
//                  ready_o=0 throughout), then normal operation.
//     undefined -> no sweep logic; ready_o=1 from the first cycle.
//
// Ports
//   clk_i, reset_n_i        clock, async active-low reset
//   v_i/ready_o             request handshake
//   w_i, addr_i, data_i,
//   mask_i                  request payload (mask only used for writes)
//   mem_v_o, mem_w_o,
//   mem_addr_o, mem_data_o,
//   mem_mask_o              SRAM port, driven in the accept cycle
//   mem_data_i              SRAM read data, valid the cycle after a read
//   v_o, data_o, yumi_i     response stream (data_o is the FIFO head)
module hard_mem_1rw_rv_adapter #(
  parameter int els_p      = 512,
  parameter int width_p    = 64,
  parameter int fifo_els_p = 3,
  localparam int addr_w    = $clog2(els_p),
  localparam int mask_w    = width_p / 8
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               v_i,
  output logic               ready_o,
  input  logic               w_i,
  input  logic [addr_w-1:0]  addr_i,
  input  logic [width_p-1:0] data_i,
  input  logic [mask_w-1:0]  mask_i,
  output logic               mem_v_o,
  output logic               mem_w_o,
  output logic [addr_w-1:0]  mem_addr_o,
  output logic [width_p-1:0] mem_data_o,
  output logic [mask_w-1:0]  mem_mask_o,
  input  logic [width_p-1:0] mem_data_i,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);

  localparam int ptr_w = (fifo_els_p > 1) ? $clog2(fifo_els_p) : 1;
  localparam int cnt_w = $clog2(fifo_els_p + 1);

  typedef enum logic {ST_INIT, ST_RUN} state_e;

`ifdef HARD_MEM_ADAPTER_ZERO_INIT_EN
  localparam state_e reset_state = ST_INIT;
`else
  localparam state_e reset_state = ST_RUN;
`endif

  state_e state_r, state_n;
  logic   init_done;

  logic                rd_pend_r;
  logic [cnt_w-1:0]    occ_r;
  logic [ptr_w-1:0]    rd_ptr_r, wr_ptr_r;
  logic [width_p-1:0]  buf_r [fifo_els_p];

  logic                accept, rd_accept, enq, deq;
  logic [cnt_w:0]      credits_used;

  function automatic logic [ptr_w-1:0] ptr_inc(input logic [ptr_w-1:0] p);
    return (p == ptr_w'(fifo_els_p - 1)) ? '0 : p + 1'b1;
  endfunction

  // ---------------- FSM ----------------
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) state_r <= reset_state;
    else            state_r <= state_n;

`ifdef HARD_MEM_ADAPTER_ZERO_INIT_EN
  logic [addr_w-1:0] init_cnt_r;

  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i)              init_cnt_r <= '0;
    else if (state_r == ST_INIT) init_cnt_r <= init_cnt_r + 1'b1;
`endif

  always_comb begin
    state_n   = state_r;
    init_done = (state_r == ST_RUN);
`ifdef HARD_MEM_ADAPTER_ZERO_INIT_EN
    if (state_r == ST_INIT && init_cnt_r == addr_w'(els_p - 1))
      state_n = ST_RUN;
`endif
  end

  // ---------------- request side ----------------
  // Credits cover both buffered words and the read still in the SRAM, so the
  // unconditional capture of mem_data_i always has a free slot.
  assign credits_used = {1'b0, occ_r} + (cnt_w + 1)'(rd_pend_r);
  assign ready_o      = init_done & (credits_used < (cnt_w + 1)'(fifo_els_p));
  assign accept       = v_i & ready_o;
  assign rd_accept    = accept & ~w_i;

  always_comb begin
    mem_v_o    = accept;
    mem_w_o    = accept & w_i;
    mem_addr_o = addr_i;
    mem_data_o = data_i;
    mem_mask_o = (accept & w_i) ? mask_i : '0;
`ifdef HARD_MEM_ADAPTER_ZERO_INIT_EN
    if (state_r == ST_INIT) begin
      mem_v_o    = 1'b1;
      mem_w_o    = 1'b1;
      mem_addr_o = init_cnt_r;
      mem_data_o = '0;
      mem_mask_o = '1;
    end
`endif
  end

  // ---------------- response FIFO ----------------
  assign enq = rd_pend_r;
  assign deq = yumi_i & v_o;

  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) begin
      rd_pend_r <= 1'b0;
      occ_r     <= '0;
      rd_ptr_r  <= '0;
      wr_ptr_r  <= '0;
    end else begin
      rd_pend_r <= rd_accept;
      if (enq) wr_ptr_r <= ptr_inc(wr_ptr_r);
      if (deq) rd_ptr_r <= ptr_inc(rd_ptr_r);
      case ({enq, deq})
        2'b10:   occ_r <= occ_r + 1'b1;
        2'b01:   occ_r <= occ_r - 1'b1;
        default: ;
      endcase
    end

  // Storage needs no reset: occ_r gates visibility of every entry.
  always_ff @(posedge clk_i)
    if (enq) buf_r[wr_ptr_r] <= mem_data_i;

  assign v_o    = (occ_r != '0);
  assign data_o = buf_r[rd_ptr_r];

endmodule

// File: tb/tb_hard_mem_1rw_rv_adapter.sv
module tb_hard_mem_1rw_rv_adapter;
  localparam int ELS = 512;
  localparam int W   = 64;
  localparam int FE  = 3;
  localparam int AW  = 9;
  localparam int MW  = 8;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic          v_i = 1'b0, w_i = 1'b0;
  logic [AW-1:0] addr_i = '0;
  logic [W-1:0]  data_i = '0;
  logic [MW-1:0] mask_i = '0;
  logic          ready_o, mem_v_o, mem_w_o, v_o, yumi_i;
  logic [AW-1:0] mem_addr_o;
  logic [W-1:0]  mem_data_o, mem_data_i, data_o;
  logic [MW-1:0] mem_mask_o;
  logic          yumi_en = 1'b0;

  assign yumi_i = yumi_en & v_o;

  hard_mem_1rw_rv_adapter #(.els_p(ELS), .width_p(W), .fifo_els_p(FE)) dut (
    .clk_i(clk), .reset_n_i(reset_n),
    .v_i(v_i), .ready_o(ready_o), .w_i(w_i), .addr_i(addr_i),
    .data_i(data_i), .mask_i(mask_i),
    .mem_v_o(mem_v_o), .mem_w_o(mem_w_o), .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o), .mem_mask_o(mem_mask_o), .mem_data_i(mem_data_i),
    .v_o(v_o), .data_o(data_o), .yumi_i(yumi_i)
  );

  // Byte-masked synchronous 1RW SRAM, one-cycle read latency
  logic [W-1:0] sram [ELS];
  logic [W-1:0] sram_q;
  always @(posedge clk)
    if (mem_v_o) begin
      if (mem_w_o) begin
        for (int b = 0; b < MW; b++)
          if (mem_mask_o[b]) sram[mem_addr_o][8*b +: 8] <= mem_data_o[8*b +: 8];
      end else
        sram_q <= sram[mem_addr_o];
    end
  assign mem_data_i = sram_q;

  // Scoreboard: expected contents and expected response order
  logic [W-1:0] shadow [ELS];
  logic [W-1:0] exp_q [$];
  logic [W-1:0] mon_exp;
  int n_chk = 0, n_bad = 0, n_resp = 0;

  function automatic void note_accept();
    if (w_i) begin
      for (int b = 0; b < MW; b++)
        if (mask_i[b]) shadow[addr_i][8*b +: 8] = data_i[8*b +: 8];
    end else
      exp_q.push_back(shadow[addr_i]);
  endfunction

  always @(negedge clk)
    if (reset_n && v_o && yumi_i) begin
      n_chk++;
      n_resp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL resp_unexpected: got data_o=%h, required no response", data_o);
      end else begin
        mon_exp = exp_q.pop_front();
        if (data_o !== mon_exp) begin
          n_bad++;
          $display("FAIL resp_data: got %h, required %h", data_o, mon_exp);
        end
      end
    end

  // Called at posedge+1; returns at posedge+1 of the cycle after the accept
  task automatic issue(input logic w, input logic [AW-1:0] a, input logic [W-1:0] d,
                       input logic [MW-1:0] m, output int waited);
    logic [MW-1:0] exp_mask;
    bit done;
    v_i = 1'b1; w_i = w; addr_i = a; data_i = d; mask_i = m;
    exp_mask = w ? m : '0;
    waited = 0;
    done = 0;
    while (!done) begin
      @(negedge clk);
      if (ready_o) begin
        n_chk++;
        if (mem_v_o !== 1'b1 || mem_w_o !== w || mem_addr_o !== a ||
            (w && mem_data_o !== d) || mem_mask_o !== exp_mask) begin
          n_bad++;
          $display("FAIL mem_port: got v=%b w=%b addr=%0d data=%h mask=%h, required v=1 w=%b addr=%0d data=%h mask=%h",
                   mem_v_o, mem_w_o, mem_addr_o, mem_data_o, mem_mask_o, w, a, d, exp_mask);
        end
        note_accept();
        done = 1;
      end else if (waited >= 200) begin
        n_chk++; n_bad++;
        $display("FAIL accept_timeout: got no accept in %0d cycles, required accept", waited);
        done = 1;
      end else
        waited++;
      @(posedge clk); #1;
    end
    v_i = 1'b0; w_i = 1'b0; mask_i = '0;
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 30 && exp_q.size() != 0; k++) begin
      @(negedge clk); #1;
    end
    n_chk++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL %s_drain: got %0d outstanding, required 0", name, exp_q.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    int cyc, sweep_bad, wt;
    logic exp_rdy;
`ifdef HARD_MEM_ADAPTER_ZERO_INIT_EN
    exp_rdy = 1'b0;
`else
    exp_rdy = 1'b1;
`endif
    reset_n = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    n_chk++; if (v_o !== 1'b0)         begin n_bad++; $display("FAIL rst_v_o: got %b, required 0", v_o); end
    n_chk++; if (mem_v_o !== 1'b0)     begin n_bad++; $display("FAIL rst_mem_v: got %b, required 0", mem_v_o); end
    n_chk++; if (mem_w_o !== 1'b0)     begin n_bad++; $display("FAIL rst_mem_w: got %b, required 0", mem_w_o); end
    n_chk++; if (mem_mask_o !== '0)    begin n_bad++; $display("FAIL rst_mem_mask: got %h, required 0", mem_mask_o); end
    n_chk++; if (ready_o !== exp_rdy)  begin n_bad++; $display("FAIL rst_ready: got %b, required %b", ready_o, exp_rdy); end
    @(posedge clk); #1;
    reset_n = 1'b1;
`ifdef HARD_MEM_ADAPTER_ZERO_INIT_EN
    cyc = 0; sweep_bad = 0;
    forever begin
      @(negedge clk);
      if (ready_o === 1'b1 || cyc >= 600) break;
      if (mem_v_o !== 1'b1 || mem_w_o !== 1'b1 || mem_addr_o !== AW'(cyc) ||
          mem_data_o !== '0 || mem_mask_o !== '1) sweep_bad++;
      cyc++;
    end
    n_chk++; if (cyc != ELS)    begin n_bad++; $display("FAIL init_len: got %0d, required %0d", cyc, ELS); end
    n_chk++; if (sweep_bad != 0) begin n_bad++; $display("FAIL init_ports: got %0d bad cycles, required 0", sweep_bad); end
    for (int i = 0; i < ELS; i++) shadow[i] = '0;
    @(posedge clk); #1;
    yumi_en = 1'b1;
    issue(1'b0, AW'(300), '0, '0, wt);
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    n_chk++; if (v_o !== 1'b1 || data_o !== '0) begin n_bad++; $display("FAIL init_read: got v=%b data=%h, required v=1 data=0", v_o, data_o); end
    @(posedge clk); #1;
`else
    @(negedge clk);
    n_chk++; if (ready_o !== 1'b1) begin n_bad++; $display("FAIL run_ready: got %b, required 1", ready_o); end
    @(posedge clk); #1;
`endif
  endtask

  task automatic test_write_read();
    int wt;
    yumi_en = 1'b1;
    issue(1'b1, AW'(5), 64'h1122334455667788, 8'hFF, wt);
    issue(1'b0, AW'(5), '0, '0, wt);
    @(negedge clk);
    n_chk++; if (v_o !== 1'b0) begin n_bad++; $display("FAIL rd_latency_early: got v_o=%b, required 0", v_o); end
    @(posedge clk); #1;
    @(negedge clk);
    n_chk++;
    if (v_o !== 1'b1 || data_o !== 64'h1122334455667788) begin
      n_bad++; $display("FAIL rd_latency: got v=%b data=%h, required v=1 data=1122334455667788", v_o, data_o);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_partial_mask();
    int wt;
    yumi_en = 1'b1;
    issue(1'b1, AW'(9), '0, 8'hFF, wt);
    issue(1'b1, AW'(9), 64'hAAAAAAAAAAAAAAAA, 8'h0F, wt);
    issue(1'b0, AW'(9), '0, '0, wt);
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    n_chk++;
    if (v_o !== 1'b1 || data_o !== 64'h00000000AAAAAAAA) begin
      n_bad++; $display("FAIL partial_mask: got v=%b data=%h, required v=1 data=00000000aaaaaaaa", v_o, data_o);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int wt, stalls;
    yumi_en = 1'b1;
    for (int i = 0; i < 4; i++) issue(1'b1, AW'(i), 64'hB0B0_0000_0000_0000 | W'(i), 8'hFF, wt);
    yumi_en = 1'b0;
    stalls = 0;
    for (int i = 0; i < 3; i++) begin
      issue(1'b0, AW'(i), '0, '0, wt);
      stalls += wt;
    end
    n_chk++; if (stalls != 0) begin n_bad++; $display("FAIL b2b_first3: got %0d stalls, required 0", stalls); end
    v_i = 1'b1; w_i = 1'b0; addr_i = AW'(3);
    stalls = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (ready_o !== 1'b0) stalls++;
      @(posedge clk); #1;
    end
    n_chk++; if (stalls != 0) begin n_bad++; $display("FAIL b2b_full: got ready_o=1 in %0d cycles, required 0", stalls); end
    yumi_en = 1'b1;
    @(negedge clk);
    n_chk++; if (ready_o !== 1'b0) begin n_bad++; $display("FAIL b2b_yumi_cycle: got ready_o=%b, required 0", ready_o); end
    @(posedge clk); #1;
    yumi_en = 1'b0;
    @(negedge clk);
    n_chk++;
    if (ready_o !== 1'b1 || mem_v_o !== 1'b1 || mem_addr_o !== AW'(3)) begin
      n_bad++; $display("FAIL b2b_reraise: got ready=%b mem_v=%b addr=%0d, required 1 1 3", ready_o, mem_v_o, mem_addr_o);
    end
    if (ready_o === 1'b1) note_accept();
    @(posedge clk); #1;
    v_i = 1'b0;
    yumi_en = 1'b1;
    drain("b2b");
  endtask

  task automatic test_streaming();
    int wt, stalls, resp0;
    yumi_en = 1'b1;
    for (int i = 0; i < 100; i++) issue(1'b1, AW'(16 + i), {$urandom, $urandom}, 8'hFF, wt);
    resp0 = n_resp;
    stalls = 0;
    for (int i = 0; i < 100; i++) begin
      issue(1'b0, AW'(16 + i), '0, '0, wt);
      stalls += wt;
    end
    n_chk++; if (stalls != 0) begin n_bad++; $display("FAIL stream_stalls: got %0d, required 0", stalls); end
    drain("stream");
    n_chk++; if (n_resp - resp0 != 100) begin n_bad++; $display("FAIL stream_count: got %0d, required 100", n_resp - resp0); end
  endtask

  task automatic test_reset_midop();
    int wt, vo_seen;
    yumi_en = 1'b0;
    for (int i = 0; i < 3; i++) issue(1'b0, AW'(16 + i), '0, '0, wt);
    // now: two words buffered, one read in flight
    reset_n = 1'b0;
    #1;
    n_chk++; if (v_o !== 1'b0)     begin n_bad++; $display("FAIL midrst_v_o: got %b, required 0", v_o); end
    n_chk++; if (mem_v_o !== 1'b0) begin n_bad++; $display("FAIL midrst_mem_v: got %b, required 0", mem_v_o); end
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    yumi_en = 1'b1;
    vo_seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (v_o !== 1'b0) vo_seen++;
    end
    n_chk++; if (vo_seen != 0) begin n_bad++; $display("FAIL midrst_stale: got v_o=1 in %0d cycles, required 0", vo_seen); end
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish, required finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_write_read();
    test_partial_mask();
    test_back_to_back();
    test_streaming();
    test_reset_midop();
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
